alu_seq: RTL and testbench

- Parametrised multi-cycle successor to the combinational ALU in RSA_PIPELINE_CPU.
- Adds iterative MUL (low N bits) and MOD (a mod b), which the RSA datapath needs for modular arithmetic.
- Keeps single-cycle ADD/SUB/AND/OR with a registered result.
- Sits in the execute stage; the pipeline stalls on ready_o and captures the result on done_o.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_divider.sv | 55 +++++
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU (alu_seq) and its divider.
package alu_seq_defs;

    typedef enum logic [2:0] {
        ADD_ = 3'b000,
        SUB_ = 3'b001,
        AND_ = 3'b010,
        OR_  = 3'b011,
        MUL_ = 3'b100,
        MOD_ = 3'b101
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_IT = 2'd1,
        MOD_IT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring-division remainder datapath with its own iteration counter.
module seq_divider
    import alu_seq_defs::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_run,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_rem_next,
    output logic         o_last
);

    logic [N:0]       r_rem;
    logic [N-1:0]     r_dividend;
    logic [N-1:0]     r_divisor;
    logic [CNT_W-1:0] r_cnt;

    logic [N:0] w_shift;
    logic [N:0] w_divisor_ext;
    logic       w_ge;
    logic [N:0] w_rem_next;

    // Bring the next dividend bit into the partial remainder.
    assign w_shift       = (r_rem << 1) | {{N{1'b0}}, r_dividend[N-1]};
    assign w_divisor_ext = {1'b0, r_divisor};
    assign w_ge          = (w_shift >= w_divisor_ext);
    assign w_rem_next    = w_ge ? (w_shift - w_divisor_ext) : w_shift;

    assign o_rem_next = w_rem_next[N-1:0];
    assign o_last     = i_run && (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_cnt      <= '0;
        end else if (i_load) begin
            r_rem      <= '0;
            r_dividend <= i_dividend;
            r_divisor  <= i_divisor;
            r_cnt      <= '0;
        end else if (i_run) begin
            r_rem      <= w_rem_next;
            r_dividend <= r_dividend << 1;
            r_cnt      <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR, iterative MUL and MOD.
// Build option ALU_SEQ_CARRY_FLAGS_EN enables carry/overflow flags for ADD/SUB.
//
// state  | meaning
// IDLE   | ready for start_i, operands sampled on accept
// MUL_IT | shift-add multiply, N iterations
// MOD_IT | restoring division in seq_divider, N iterations
// DONE   | done_o pulse, result/flags/err valid
module alu_seq
    import alu_seq_defs::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   opcode_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic [3:0]   flags_o,
    output logic         err_o
);

    localparam int CNT_W = $clog2(N) + 1;

    state_t r_state;
    state_t w_state_next;

    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_mplier;
    logic [N-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_result;
    logic [3:0]       r_flags;
    logic             r_err;

    logic         w_accept;
    logic         w_mul_last;
    logic [N-1:0] w_acc_next;
    logic         w_div_load;
    logic         w_div_run;
    logic         w_div_last;
    logic [N-1:0] w_div_rem;
    logic [N-1:0] w_res;
    logic         w_c;
    logic         w_v;
    logic         w_err;

`ifdef ALU_SEQ_CARRY_FLAGS_EN
    logic [N:0] w_sum;
    logic [N:0] w_diff;
    assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
    assign w_diff = {1'b0, a_i} - {1'b0, b_i};
`else
    logic [N-1:0] w_sum;
    logic [N-1:0] w_diff;
    assign w_sum  = a_i + b_i;
    assign w_diff = a_i - b_i;
`endif

    function automatic logic [3:0] pack_flags(input logic [N-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[N-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign w_accept   = start_i && (r_state == IDLE);
    assign w_mul_last = (r_state == MUL_IT) && (r_cnt == CNT_W'(N - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_div_load = w_accept && (opcode_i == MOD_) && (b_i != '0);
    assign w_div_run  = (r_state == MOD_IT);

    seq_divider #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_div (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (w_div_load),
        .i_run      (w_div_run),
        .i_dividend (a_i),
        .i_divisor  (b_i),
        .o_rem_next (w_div_rem),
        .o_last     (w_div_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (opcode_i == MUL_)
                        w_state_next = MUL_IT;
                    else if ((opcode_i == MOD_) && (b_i != '0))
                        w_state_next = MOD_IT;
                    else
                        w_state_next = DONE;
                end
            end
            MUL_IT:  if (w_mul_last) w_state_next = DONE;
            MOD_IT:  if (w_div_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (r_state == IDLE);
        done_o  = (r_state == DONE);
    end

    // Single-cycle result; the MOD entry only matters for the divide-by-zero case.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (opcode_t'(opcode_i))
            ADD_: begin
                w_res = w_sum[N-1:0];
`ifdef ALU_SEQ_CARRY_FLAGS_EN
                w_c = w_sum[N];
                w_v = (a_i[N-1] == b_i[N-1]) && (w_sum[N-1] != a_i[N-1]);
`endif
            end
            SUB_: begin
                w_res = w_diff[N-1:0];
`ifdef ALU_SEQ_CARRY_FLAGS_EN
                w_c = ~w_diff[N];
                w_v = (a_i[N-1] != b_i[N-1]) && (w_diff[N-1] != a_i[N-1]);
`endif
            end
            AND_: w_res = a_i & b_i;
            OR_:  w_res = a_i | b_i;
            MOD_: begin
                w_res = a_i;
                w_err = 1'b1;
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= a_i;
            r_mplier <= b_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            if (w_state_next == DONE) begin
                r_result <= w_res;
                r_flags  <= pack_flags(w_res, w_c, w_v);
                r_err    <= w_err;
            end
        end else if (r_state == MUL_IT) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_result <= w_acc_next;
                r_flags  <= pack_flags(w_acc_next, 1'b0, 1'b0);
                r_err    <= 1'b0;
            end
        end else if (w_div_last) begin
            r_result <= w_div_rem;
            r_flags  <= pack_flags(w_div_rem, 1'b0, 1'b0);
            r_err    <= 1'b0;
        end
    end

    assign result_o = r_result;
    assign flags_o  = r_flags;
    assign err_o    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at N=8.
module tb_alu_seq;

    localparam int N = 8;
`ifdef ALU_SEQ_CARRY_FLAGS_EN
    localparam logic [3:0] CV_MASK = 4'b1111;
`else
    localparam logic [3:0] CV_MASK = 4'b0011;
`endif

    logic         clk_i    = 1'b0;
    logic         rst_i    = 1'b1;
    logic         start_i  = 1'b0;
    logic [N-1:0] a_i      = '0;
    logic [N-1:0] b_i      = '0;
    logic [2:0]   opcode_i = '0;
    logic         ready_o;
    logic         done_o;
    logic [N-1:0] result_o;
    logic [3:0]   flags_o;
    logic         err_o;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.N(N)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .opcode_i (opcode_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .result_o (result_o),
        .flags_o  (flags_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one op, wait for done_o, check latency, busy time, result and pulse width.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input int exp_lat, input logic [N-1:0] exp_res,
                          input logic [3:0] exp_flags, input logic exp_err);
        int lat;
        int busy;
        @(negedge clk_i);
        opcode_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat  = 1;
        busy = 0;
        while (!done_o && lat < 40) begin
            if (!ready_o) busy++;
            @(posedge clk_i); #1;
            lat++;
        end
        if (!ready_o) busy++;
        check({tag, ".lat"},   lat, exp_lat);
        check({tag, ".busy"},  busy, exp_lat);
        check({tag, ".res"},   result_o, exp_res);
        check({tag, ".flags"}, flags_o & CV_MASK, exp_flags & CV_MASK);
        check({tag, ".err"},   err_o, exp_err);
        @(posedge clk_i); #1;
        check({tag, ".pulse"}, done_o, 1'b0);
        check({tag, ".rdy"},   ready_o, 1'b1);
    endtask

    initial begin
        int lat;
        int seen;

        #12;
        check("rst.ready",  ready_o, 1'b1);
        check("rst.done",   done_o, 1'b0);
        check("rst.result", result_o, 0);
        check("rst.flags",  flags_o, 0);
        check("rst.err",    err_o, 1'b0);
        @(negedge clk_i); rst_i = 1'b0;

        //      tag        op      a    b    lat res  {V,C,N,Z} err
        run_op("add",     3'b000, 200, 100, 1, 44,  4'b0100, 1'b0);
        run_op("add_wrap",3'b000, 255, 1,   1, 0,   4'b0101, 1'b0);
        run_op("sub_neg", 3'b001, 5,   7,   1, 254, 4'b0010, 1'b0);
        run_op("sub_ovf", 3'b001, 128, 1,   1, 127, 4'b1100, 1'b0);
        run_op("and",     3'b010, 8'hCC, 8'hAA, 1, 8'h88, 4'b0010, 1'b0);
        run_op("mul",     3'b100, 13,  11,  9, 143, 4'b0010, 1'b0);
        run_op("mul_zero",3'b100, 16,  16,  9, 0,   4'b0001, 1'b0);
        run_op("mul_max", 3'b100, 255, 255, 9, 1,   4'b0000, 1'b0);
        run_op("mod",     3'b101, 200, 7,   9, 4,   4'b0000, 1'b0);
        run_op("mod_max", 3'b101, 255, 16,  9, 15,  4'b0000, 1'b0);
        run_op("mod_small",3'b101, 5,  200, 9, 5,   4'b0000, 1'b0);
        run_op("mod_by0", 3'b101, 9,   0,   1, 9,   4'b0000, 1'b1);
        run_op("illegal", 3'b110, 77,  3,   1, 0,   4'b0001, 1'b1);
        run_op("illegal7",3'b111, 200, 100, 1, 0,   4'b0001, 1'b1);

        // start_i pulsed with ADD while MUL iterates must be ignored
        @(negedge clk_i);
        opcode_i = 3'b100; a_i = 13; b_i = 11; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = 1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            lat++;
        end
        @(negedge clk_i);
        opcode_i = 3'b000; a_i = 1; b_i = 1; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat++;
        while (!done_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("ign.lat", lat, 9);
        check("ign.res", result_o, 143);
        check("ign.err", err_o, 1'b0);
        @(posedge clk_i); #1;

        // reset in the middle of a MUL
        @(negedge clk_i);
        opcode_i = 3'b100; a_i = 13; b_i = 11; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
        end
        @(negedge clk_i); rst_i = 1'b1;
        #1;
        check("midrst.ready",  ready_o, 1'b1);
        check("midrst.result", result_o, 0);
        check("midrst.done",   done_o, 1'b0);
        check("midrst.flags",  flags_o, 0);
        @(negedge clk_i); rst_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk_i); #1;
            if (done_o) seen++;
        end
        check("midrst.nodone", seen, 0);

        // back-to-back with start_i held high
        @(negedge clk_i);
        opcode_i = 3'b000; a_i = 1; b_i = 1; start_i = 1'b1;
        @(posedge clk_i); #1;
        check("b2b.done1", done_o, 1'b1);
        check("b2b.res1",  result_o, 2);
        opcode_i = 3'b011; a_i = 8'h0F; b_i = 8'hF0;
        @(posedge clk_i); #1;
        check("b2b.gap",   done_o, 1'b0);
        check("b2b.rdy",   ready_o, 1'b1);
        @(posedge clk_i); #1;
        check("b2b.done2", done_o, 1'b1);
        check("b2b.res2",  result_o, 255);
        check("b2b.flags2", flags_o & CV_MASK, 4'b0010);
        start_i = 1'b0;
        @(posedge clk_i); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
